// File: rtl/irq_arbiter_ctrl_if.sv
// irq_arbiter_ctrl_if: CPU-facing irq bundle.
// master = controller side, slave = CPU/stimulus side.
interface irq_arbiter_ctrl_if #(
  parameter int N_IRQ = 4,
  parameter int ID_W  = $clog2(N_IRQ)
);
  logic [N_IRQ-1:0] irq_in;
  logic [N_IRQ-1:0] mask;
  logic             int_req;
  logic [ID_W-1:0]  int_id;
  logic             int_ack;
  logic             eoi;
  logic [N_IRQ-1:0] pending;
  logic [N_IRQ-1:0] in_service;

  modport master (
    input  irq_in, mask, int_ack, eoi,
    output int_req, int_id, pending, in_service
  );

  modport slave (
    output irq_in, mask, int_ack, eoi,
    input  int_req, int_id, pending, in_service
  );
endinterface

// File: rtl/irq_arbiter_ctrl.sv
// irq_arbiter_ctrl: edge-latched, masked, fixed-priority
// irq controller with req/ack handshake and EOI tracking.
module irq_arbiter_ctrl #(
  parameter int N_IRQ = 4,
  parameter int ID_W  = $clog2(N_IRQ)
) (
  input logic                clock,
  input logic                resetN,
  irq_arbiter_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SERVICE
  } state_t;

  state_t           state;
  logic [N_IRQ-1:0] irq_prev;
  logic [N_IRQ-1:0] pend_q;
  logic [N_IRQ-1:0] insvc_q;
  logic             req_q;
  logic [ID_W-1:0]  id_q;

  logic [N_IRQ-1:0] rise;
  logic [N_IRQ-1:0] cand;
  logic [N_IRQ-1:0] id_oh;
  logic [N_IRQ-1:0] ack_clr;
  logic             ack_ok;
  logic [ID_W-1:0]  win;

  assign rise    = bus.irq_in & ~irq_prev;
  assign cand    = pend_q & ~bus.mask;
  assign id_oh   = N_IRQ'(1) << id_q;
  assign ack_ok  = (state == REQ) && bus.int_ack;
  assign ack_clr = ack_ok ? id_oh : '0;

  // Lowest set candidate index wins (irq 0 highest).
  always_comb begin
    win = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (cand[i]) win = ID_W'(i);
    end
  end

  // Edge latch, pending set-over-clear and handshake FSM.
  always_ff @(posedge clock) begin
    if (!resetN) begin
      state    <= IDLE;
      irq_prev <= '0;
      pend_q   <= '0;
      insvc_q  <= '0;
      req_q    <= 1'b0;
      id_q     <= '0;
    end else begin
      irq_prev <= bus.irq_in;
      pend_q   <= (pend_q & ~ack_clr) | rise;
      unique case (state)
        IDLE: begin
          if (|cand) begin
            id_q  <= win;
            req_q <= 1'b1;
            state <= REQ;
          end
        end
        REQ: begin
          if (bus.int_ack) begin
            req_q   <= 1'b0;
            insvc_q <= id_oh;
            state   <= SERVICE;
          end
        end
        SERVICE: begin
          if (bus.eoi) begin
            insvc_q <= '0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.int_req    = req_q;
  assign bus.int_id     = id_q;
  assign bus.pending    = pend_q;
  assign bus.in_service = insvc_q;

endmodule

// File: tb/tb_irq_arbiter_ctrl.sv
// tb_irq_arbiter_ctrl: directed scenarios plus random
// traffic against a behavioural controller model.
module tb_irq_arbiter_ctrl;

  logic clock = 1'b0;
  logic resetN;
  int   errors = 0;
  int   checks = 0;

  irq_arbiter_ctrl_if #(.N_IRQ(4)) bus ();

  irq_arbiter_ctrl #(.N_IRQ(4)) dut (
    .clock  (clock),
    .resetN (resetN),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  // Model: set of pending sources, one outstanding request,
  // one source in service (-1 = none).
  bit [3:0] m_pend;
  bit [3:0] m_prev;
  bit       m_req;
  int       m_id;
  int       m_svc;

  task automatic model_step();
    bit [3:0] rise;
    bit [3:0] np;
    int       w;
    if (!resetN) begin
      m_pend = '0;
      m_prev = '0;
      m_req  = 1'b0;
      m_id   = 0;
      m_svc  = -1;
      return;
    end
    rise = bus.irq_in & ~m_prev;
    np   = m_pend;
    if (m_req && bus.int_ack) np[m_id] = 1'b0;
    np = np | rise;
    if (m_req) begin
      if (bus.int_ack) begin
        m_req = 1'b0;
        m_svc = m_id;
      end
    end else if (m_svc >= 0) begin
      if (bus.eoi) m_svc = -1;
    end else begin
      w = -1;
      for (int i = 3; i >= 0; i--)
        if (m_pend[i] && !bus.mask[i]) w = i;
      if (w >= 0) begin
        m_req = 1'b1;
        m_id  = w;
      end
    end
    m_pend = np;
    m_prev = bus.irq_in;
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
  endtask

  function automatic logic [10:0] obs();
    logic [1:0] id;
    id = bus.int_req ? bus.int_id : 2'd0;
    return {bus.int_req, id, bus.pending, bus.in_service};
  endfunction

  function automatic logic [10:0] expv();
    logic [1:0] id;
    logic [3:0] sv;
    id = m_req ? m_id[1:0] : 2'd0;
    sv = (m_svc >= 0) ? (4'b0001 << m_svc) : 4'b0000;
    return {m_req, id, m_pend, sv};
  endfunction

  task automatic test_reset();
    resetN = 1'b0;
    bus.irq_in = '0; bus.mask = '0;
    bus.int_ack = 1'b0; bus.eoi = 1'b0;
    tick(); tick();
    checks++;
    if (bus.int_req !== 1'b0) begin
      errors++;
      $display("FAIL rst_req got=%b want=0", bus.int_req);
    end
    checks++;
    if (bus.int_id !== 2'd0) begin
      errors++;
      $display("FAIL rst_id got=%0d want=0", bus.int_id);
    end
    checks++;
    if (bus.pending !== 4'b0) begin
      errors++;
      $display("FAIL rst_pend got=%b want=0000", bus.pending);
    end
    checks++;
    if (bus.in_service !== 4'b0) begin
      errors++;
      $display("FAIL rst_svc got=%b want=0000", bus.in_service);
    end
    resetN = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    bus.irq_in = 4'b0010;
    tick();
    checks++;
    if ({bus.int_req, bus.pending} !== 5'b0_0010) begin
      errors++;
      $display("FAIL basic_pend got=%b_%b want=0_0010",
               bus.int_req, bus.pending);
    end
    tick();
    checks++;
    if ({bus.int_req, bus.int_id} !== 3'b1_01) begin
      errors++;
      $display("FAIL basic_req got=%b/%0d want=1/1",
               bus.int_req, bus.int_id);
    end
    bus.int_ack = 1'b1; tick(); bus.int_ack = 1'b0;
    checks++;
    if ({bus.int_req, bus.pending, bus.in_service} !== 9'b0_0000_0010) begin
      errors++;
      $display("FAIL basic_ack got=%b/%b/%b want=0/0000/0010",
               bus.int_req, bus.pending, bus.in_service);
    end
    bus.eoi = 1'b1; tick(); bus.eoi = 1'b0;
    bus.irq_in = '0; tick();
    checks++;
    if ({bus.int_req, bus.in_service} !== 5'b0_0000) begin
      errors++;
      $display("FAIL basic_eoi got=%b/%b want=0/0000",
               bus.int_req, bus.in_service);
    end
  endtask

  task automatic test_simultaneous();
    bus.irq_in = 4'b1010;
    tick(); tick();
    checks++;
    if ({bus.int_req, bus.int_id} !== 3'b1_01) begin
      errors++;
      $display("FAIL simul_first got=%b/%0d want=1/1",
               bus.int_req, bus.int_id);
    end
    bus.int_ack = 1'b1; tick(); bus.int_ack = 1'b0;
    bus.eoi = 1'b1; tick(); bus.eoi = 1'b0;
    tick();
    checks++;
    if ({bus.int_req, bus.int_id} !== 3'b1_11) begin
      errors++;
      $display("FAIL simul_second got=%b/%0d want=1/3",
               bus.int_req, bus.int_id);
    end
    bus.int_ack = 1'b1; tick(); bus.int_ack = 1'b0;
    bus.eoi = 1'b1; tick(); bus.eoi = 1'b0;
    bus.irq_in = '0; tick();
    checks++;
    if (bus.pending !== 4'b0) begin
      errors++;
      $display("FAIL simul_pend got=%b want=0000", bus.pending);
    end
  endtask

  task automatic test_mask();
    bus.mask = 4'b0001;
    bus.irq_in = 4'b0101;
    tick(); tick();
    checks++;
    if ({bus.int_req, bus.int_id} !== 3'b1_10) begin
      errors++;
      $display("FAIL mask_win got=%b/%0d want=1/2",
               bus.int_req, bus.int_id);
    end
    bus.int_ack = 1'b1; tick(); bus.int_ack = 1'b0;
    bus.mask = 4'b0000;
    tick();
    checks++;
    if ({bus.int_req, bus.in_service} !== 5'b0_0100) begin
      errors++;
      $display("FAIL mask_svc got=%b/%b want=0/0100",
               bus.int_req, bus.in_service);
    end
    bus.eoi = 1'b1; tick(); bus.eoi = 1'b0;
    tick();
    checks++;
    if ({bus.int_req, bus.int_id} !== 3'b1_00) begin
      errors++;
      $display("FAIL mask_unmask got=%b/%0d want=1/0",
               bus.int_req, bus.int_id);
    end
    bus.int_ack = 1'b1; tick(); bus.int_ack = 1'b0;
    bus.eoi = 1'b1; tick(); bus.eoi = 1'b0;
    bus.irq_in = '0; tick();
  endtask

  task automatic test_no_preempt();
    bus.irq_in = 4'b0100;
    tick(); tick();
    bus.irq_in = 4'b0101;
    tick(); tick(); tick();
    checks++;
    if ({bus.int_req, bus.int_id, bus.pending} !== 7'b1_10_0101) begin
      errors++;
      $display("FAIL preempt_hold got=%b/%0d/%b want=1/2/0101",
               bus.int_req, bus.int_id, bus.pending);
    end
    bus.int_ack = 1'b1; tick(); bus.int_ack = 1'b0;
    bus.eoi = 1'b1; tick(); bus.eoi = 1'b0;
    tick();
    checks++;
    if ({bus.int_req, bus.int_id} !== 3'b1_00) begin
      errors++;
      $display("FAIL preempt_next got=%b/%0d want=1/0",
               bus.int_req, bus.int_id);
    end
    bus.int_ack = 1'b1; tick(); bus.int_ack = 1'b0;
    bus.eoi = 1'b1; tick(); bus.eoi = 1'b0;
    bus.irq_in = '0; tick();
  endtask

  task automatic test_reack_stray();
    bus.irq_in = 4'b0010; tick();
    bus.irq_in = 4'b0000; tick();
    bus.irq_in = 4'b0010; bus.int_ack = 1'b1;
    tick(); bus.int_ack = 1'b0;
    checks++;
    if ({bus.pending, bus.in_service} !== 8'b0010_0010) begin
      errors++;
      $display("FAIL reack_set got=%b/%b want=0010/0010",
               bus.pending, bus.in_service);
    end
    bus.int_ack = 1'b1; tick(); bus.int_ack = 1'b0;
    checks++;
    if ({bus.int_req, bus.pending, bus.in_service} !== 9'b0_0010_0010) begin
      errors++;
      $display("FAIL stray_ack got=%b/%b/%b want=0/0010/0010",
               bus.int_req, bus.pending, bus.in_service);
    end
    bus.eoi = 1'b1; tick(); bus.eoi = 1'b0;
    tick();
    checks++;
    if ({bus.int_req, bus.int_id} !== 3'b1_01) begin
      errors++;
      $display("FAIL reack_again got=%b/%0d want=1/1",
               bus.int_req, bus.int_id);
    end
    bus.int_ack = 1'b1; tick(); bus.int_ack = 1'b0;
    bus.eoi = 1'b1; tick(); bus.eoi = 1'b0;
    bus.irq_in = '0; tick();
    bus.eoi = 1'b1; bus.int_ack = 1'b1; tick();
    bus.eoi = 1'b0; bus.int_ack = 1'b0; tick();
    checks++;
    if ({bus.int_req, bus.pending, bus.in_service} !== 9'b0) begin
      errors++;
      $display("FAIL stray_eoi got=%b/%b/%b want=0/0000/0000",
               bus.int_req, bus.pending, bus.in_service);
    end
  endtask

  task automatic test_mid_reset();
    bus.irq_in = 4'b0001; tick(); tick();
    bus.int_ack = 1'b1; tick(); bus.int_ack = 1'b0;
    bus.irq_in = 4'b0101; tick();
    checks++;
    if (bus.in_service !== 4'b0001) begin
      errors++;
      $display("FAIL mrst_pre got=%b want=0001", bus.in_service);
    end
    resetN = 1'b0; tick();
    checks++;
    if ({bus.int_req, bus.pending, bus.in_service} !== 9'b0) begin
      errors++;
      $display("FAIL mrst_clear got=%b/%b/%b want=0/0000/0000",
               bus.int_req, bus.pending, bus.in_service);
    end
    resetN = 1'b1; tick();
    checks++;
    if (bus.pending !== 4'b0101) begin
      errors++;
      $display("FAIL mrst_edge got=%b want=0101", bus.pending);
    end
    tick();
    checks++;
    if ({bus.int_req, bus.int_id} !== 3'b1_00) begin
      errors++;
      $display("FAIL mrst_req got=%b/%0d want=1/0",
               bus.int_req, bus.int_id);
    end
    checks++;
    if (obs() !== expv()) begin
      errors++;
      $display("FAIL mrst_model got=%b want=%b", obs(), expv());
    end
    bus.irq_in = '0;
    resetN = 1'b0; tick();
    resetN = 1'b1; tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      resetN      = ($urandom_range(0, 149) != 0);
      bus.irq_in  = bus.irq_in ^ (4'($urandom) & 4'($urandom));
      if ($urandom_range(0, 9) == 0) bus.mask = 4'($urandom);
      bus.int_ack = ($urandom_range(0, 2) == 0);
      bus.eoi     = ($urandom_range(0, 3) == 0);
      tick();
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL rand_c%0d got=%b want=%b", c, obs(), expv());
      end
    end
    bus.int_ack = 1'b0;
    bus.eoi = 1'b0;
  endtask

  initial begin
    m_svc = -1;
    test_reset();
    test_basic();
    test_simultaneous();
    test_mask();
    test_no_preempt();
    test_reack_stray();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
